multicycle_subtractor: RTL and testbench
========================================

MULTICYCLE_SUBTRACTOR -- requirements
Module: multicycle_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-006 The block SHALL have port a, input, WIDTH bits: minuend.
REQ-007 The block SHALL have port b, input, WIDTH bits: subtrahend.
REQ-008 The block SHALL have port borrow_in, input, 1 bit: initial borrow into bit 0.
REQ-009 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement overflow rule, 0 = unsigned.
REQ-010 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port result, output, WIDTH bits: a - b - borrow_in modulo 2^WIDTH.
REQ-013 The block SHALL have port borrow, output, 1 bit: borrow out of the MSB.
REQ-014 The block SHALL have port overflow, output, 1 bit: mode-dependent overflow flag.
REQ-015 The block SHALL have port zero, output, 1 bit: result equals 0.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 In IDLE or DONE, start=1 at an edge SHALL capture a, b, borrow_in and signed_mode into internal registers, clear the chunk index to 0, and enter RUN.
REQ-018 In RUN, each edge SHALL compute chunk k of the captured operands as A[k] - B[k] - borrow_chain over CHUNK bits, store the difference in the working register, propagate the chunk borrow to the next cycle, and increment k.
REQ-019 After the edge that processes chunk NCHUNK-1, the FSM SHALL enter DONE.
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE unless a new start is accepted per REQ-017.
REQ-021 Latency: with start accepted at edge T, done SHALL be high during the cycle after edge T+NCHUNK.
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 done SHALL be 1 exactly while in DONE.
REQ-024 start SHALL be ignored while in RUN, and the captured operands SHALL be unaffected by input changes during RUN.
REQ-025 result, borrow, overflow and zero SHALL update only on the edge entering DONE and SHALL hold until the next completion; no partial results SHALL be visible.
REQ-026 borrow SHALL be the final borrow out of the MSB chunk.
REQ-027 With signed_mode=1, overflow SHALL be (a[MSB] != b[MSB]) AND (result[MSB] != a[MSB]), using the captured operands.
REQ-028 With signed_mode=0, overflow SHALL equal borrow.
REQ-029 zero SHALL be 1 iff all result bits are 0.
REQ-030 When NCHUNK=1, the block SHALL remain legal, with RUN lasting one cycle.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, clear busy, done, result, borrow, overflow and the working registers to 0, and set zero to 1; rst SHALL take priority over start.
REQ-032 rst asserted during RUN SHALL abort the operation with no done pulse, and a start after reset release SHALL operate normally.

Verification (WIDTH=16, CHUNK=4)
REQ-033 The bench SHALL cover: a=0x0005, b=0x0003, borrow_in=0, unsigned -> result=0x0002, borrow=0, overflow=0, zero=0, done in the cycle after edge T+4, busy high for 4 cycles.
REQ-034 The bench SHALL cover: a=0x0000, b=0x0001, unsigned -> result=0xFFFF, borrow=1, overflow=1, zero=0.
REQ-035 The bench SHALL cover: a=0x8000, b=0x0001, signed_mode=1 -> result=0x7FFF, borrow=0, overflow=1; and a=0x0001, b=0x0002, signed -> result=0xFFFF, overflow=0, borrow=1.
REQ-036 The bench SHALL cover: a=0x0010, b=0x000F, borrow_in=1 -> result=0x0000, zero=1, borrow=0; this exercises inter-chunk borrow.
REQ-037 The bench SHALL cover: start re-asserted with new operands during RUN -> ignored, and the original result is delivered; start asserted in the DONE cycle -> the new operation begins immediately and busy rises on the next cycle.
REQ-038 The bench SHALL cover: rst pulsed at RUN cycle 2 -> no done pulse, all outputs at their reset values, and the next start completes correctly.

Source files
------------

// File: rtl/multicycle_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_subtractor_if
// Description : Handshake and operand/result bundle for multicycle_subtractor.
//               master : drives start, a, b, borrow_in, signed_mode and
//                        observes busy, done, result, borrow, overflow, zero.
//               slave  : the subtractor side of the same signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b, borrow_in, signed_mode,
        input  busy, done, result, borrow, overflow, zero
    );

    modport slave (
        input  start, a, b, borrow_in, signed_mode,
        output busy, done, result, borrow, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_subtractor
// Description : Computes a - b - borrow_in modulo 2^WIDTH, CHUNK bits per
//               clock, least significant chunk first. Operands are captured
//               when start is accepted (IDLE or DONE); the flags and result
//               only change on the edge that enters DONE, so no partial
//               difference is ever visible on the outputs.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset (wins over start)
//               bus  - multicycle_subtractor_if.slave:
//                      start, a, b, borrow_in, signed_mode (in)
//                      busy, done, result, borrow, overflow, zero (out)
// Parameters  : WIDTH - operand/result width; must be a multiple of CHUNK
//               CHUNK - bits processed per clock
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    multicycle_subtractor_if.slave bus
);

    localparam int c_nchunk = WIDTH / CHUNK;
    // Index register is at least one bit wide so a single-chunk build works.
    localparam int c_kw     = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam logic [c_kw-1:0] c_last_k = c_kw'(c_nchunk - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_chain;
    logic             r_signed;
    logic [c_kw-1:0]  r_k;
    logic [WIDTH-1:0] r_work;

    logic [WIDTH-1:0] r_result;
    logic             r_borrow;
    logic             r_overflow;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    int               w_base;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_diff;
    logic [WIDTH-1:0] w_work_next;
    logic             w_ovf_signed;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign w_accept = (r_state != S_RUN) && bus.start;
    assign w_last   = (r_k == c_last_k);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // A start in the completion cycle chains straight into RUN.
                w_next_state = bus.start ? S_RUN : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Chunk datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_base    = int'(r_k) * CHUNK;
        w_a_chunk = r_a[w_base +: CHUNK];
        w_b_chunk = r_b[w_base +: CHUNK];
        // The extra top bit of the widened difference is the chunk borrow.
        w_diff    = {1'b0, w_a_chunk} - {1'b0, w_b_chunk}
                  - {{CHUNK{1'b0}}, r_chain};
        w_work_next                   = r_work;
        w_work_next[w_base +: CHUNK]  = w_diff[CHUNK-1:0];
    end

    // Signed overflow: operands of opposite sign and the result sign
    // disagrees with the minuend.
    assign w_ovf_signed = (r_a[WIDTH-1] != r_b[WIDTH-1])
                       && (w_work_next[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_chain    <= 1'b0;
            r_signed   <= 1'b0;
            r_k        <= '0;
            r_work     <= '0;
            r_result   <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_chain  <= bus.borrow_in;
            r_signed <= bus.signed_mode;
            r_k      <= '0;
            r_work   <= '0;
        end else if (r_state == S_RUN) begin
            r_work  <= w_work_next;
            r_chain <= w_diff[CHUNK];
            r_k     <= r_k + c_kw'(1);
            if (w_last) begin
                r_result   <= w_work_next;
                r_borrow   <= w_diff[CHUNK];
                r_overflow <= r_signed ? w_ovf_signed : w_diff[CHUNK];
                r_zero     <= (w_work_next == '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.result   = r_result;
    assign bus.borrow   = r_borrow;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_subtractor
// Description : Self-checking bench for multicycle_subtractor (WIDTH=16,
//               CHUNK=4). A whole-word arithmetic model predicts every
//               output each cycle; directed operations also check literal
//               hand-computed results and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_subtractor;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int NC = W / CH;

    logic clk;
    logic rst;

    int n_cmp;
    int n_bad;

    multicycle_subtractor_if #(.WIDTH(W)) bus ();

    multicycle_subtractor #(
        .WIDTH (W),
        .CHUNK (CH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: whole-word subtraction with a countdown for latency
    // ------------------------------------------------------------------
    int           m_rem;
    logic         m_valid;
    logic         m_done;
    logic [W-1:0] m_res,  p_res;
    logic         m_brw,  p_brw;
    logic         m_ovf,  p_ovf;
    logic         m_zero, p_zero;

    initial begin
        logic [W:0] full;
        m_valid = 1'b0;
        m_rem   = 0;
        m_done  = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b1;
                m_rem   = 0;
                m_done  = 1'b0;
                m_res   = '0;
                m_brw   = 1'b0;
                m_ovf   = 1'b0;
                m_zero  = 1'b1;
            end else if (m_rem > 0) begin
                m_rem--;
                m_done = 1'b0;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_res  = p_res;
                    m_brw  = p_brw;
                    m_ovf  = p_ovf;
                    m_zero = p_zero;
                end
            end else begin
                m_done = 1'b0;
                if (bus.start) begin
                    full   = {1'b0, bus.a} - {1'b0, bus.b} - {{W{1'b0}}, bus.borrow_in};
                    p_res  = full[W-1:0];
                    p_brw  = full[W];
                    p_ovf  = bus.signed_mode
                           ? ((bus.a[W-1] != bus.b[W-1]) && (p_res[W-1] != bus.a[W-1]))
                           : p_brw;
                    p_zero = (p_res == '0);
                    m_rem  = NC;
                end
            end
            #1;
            if (m_valid) begin
                chk("busy",     32'(bus.busy),     32'(m_rem > 0));
                chk("done",     32'(bus.done),     32'(m_done));
                chk("result",   32'(bus.result),   32'(m_res));
                chk("borrow",   32'(bus.borrow),   32'(m_brw));
                chk("overflow", 32'(bus.overflow), 32'(m_ovf));
                chk("zero",     32'(bus.zero),     32'(m_zero));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after a rising edge)
    // ------------------------------------------------------------------
    task automatic drive(input logic s, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic bi, input logic sm);
        bus.start       = s;
        bus.a           = ta;
        bus.b           = tb_;
        bus.borrow_in   = bi;
        bus.signed_mode = sm;
    endtask

    // Called 2 units after the accepting edge; returns at 1 unit after the
    // edge that raises done, with the number of edges counted.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic bi, input logic sm,
                         input logic [W-1:0] er, input logic eb, input logic eo, input logic ez);
        int cyc;
        @(posedge clk); #2;
        drive(1'b1, ta, tb_, bi, sm);
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done(cyc);
        chk({nm, "_latency"},  32'(cyc),          32'(NC));
        chk({nm, "_result"},   32'(bus.result),   32'(er));
        chk({nm, "_borrow"},   32'(bus.borrow),   32'(eb));
        chk({nm, "_overflow"}, 32'(bus.overflow), 32'(eo));
        chk({nm, "_zero"},     32'(bus.zero),     32'(ez));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_zero",   32'(bus.zero),   32'd1);
        #1;
        rst = 1'b0;

        do_op("basic",   16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        do_op("uwrap",   16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        do_op("sovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        do_op("sneg",    16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        do_op("chain",   16'h0010, 16'h000F, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // start and operand changes during RUN must be ignored
        @(posedge clk); #2;
        drive(1'b1, 16'h1234, 16'h0234, 1'b0, 1'b0);
        @(posedge clk); #2;
        bus.start = 1'b0;
        @(posedge clk); #2;
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        @(posedge clk); #2;
        drive(1'b0, 16'h0AAA, 16'h0555, 1'b0, 1'b1);
        wait_done(cyc);
        chk("ignore_done",   32'(bus.done),   32'd1);
        chk("ignore_result", 32'(bus.result), 32'h1000);

        // start during the DONE cycle chains straight into a new RUN
        #1;
        drive(1'b1, 16'h0009, 16'h0004, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("chain_busy", 32'(bus.busy), 32'd1);
        #1;
        bus.start = 1'b0;
        wait_done(cyc);
        chk("chain_latency", 32'(cyc),        32'(NC));
        chk("chain_result",  32'(bus.result), 32'h0005);

        // reset in RUN cycle 2 aborts with no done pulse
        @(posedge clk); #2;
        drive(1'b1, 16'h4321, 16'h0021, 1'b0, 1'b0);
        @(posedge clk); #2;
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy",     32'(bus.busy),     32'd0);
        chk("abort_done",     32'(bus.done),     32'd0);
        chk("abort_result",   32'(bus.result),   32'd0);
        chk("abort_borrow",   32'(bus.borrow),   32'd0);
        chk("abort_overflow", 32'(bus.overflow), 32'd0);
        chk("abort_zero",     32'(bus.zero),     32'd1);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        do_op("post_rst", 16'h00FF, 16'h000F, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
